ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 command transmitter, the sending direction that complements the existing PS/2 receivers (keyboard_wb, ps2_mouse). It lets the core send command bytes to an attached PS/2 device, e.g. 0xF4 "enable data reporting" or 0xFF "reset", following the PS/2 host request-to-send procedure. Lines are open-collector: the block only ever pulls a line low or releases it, and a pad wrapper at the top level drives the physical pins. It runs on `wb_clk` (4 MHz) next to ps2_mouse. Its `tx_busy` output gates the receiver so the receiver ignores the transfer.

## Interface
- `INHIBIT_CYC`, 400: clock cycles the host holds PS/2 clock low before the request (100 µs at 4 MHz).
- `TIMEOUT_CYC`, 60000: maximum cycles from request-to-send until the ACK is complete (15 ms at 4 MHz).
- `clk`  in  1  system clock (`wb_clk`).
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  command byte; sampled when `tx_stb` is accepted.
- `tx_stb`  in  1  one-cycle start request.
- `tx_busy`  out  1  high while a transfer is in progress.
- `tx_done`  out  1  one-cycle pulse: transfer finished and ACK received.
- `tx_err`  out  1  one-cycle pulse: no ACK was received, or the transfer timed out.
- `ps2_clk_i`  in  1  PS/2 clock pin level (asynchronous).
- `ps2_dat_i`  in  1  PS/2 data pin level (asynchronous).
- `ps2_clk_oe`  out  1  1 pulls PS/2 clock low; 0 releases it.
- `ps2_dat_oe`  out  1  1 pulls PS/2 data low; 0 releases it.

## Operation
- **Input synchronisers.** `ps2_clk_i` and `ps2_dat_i` each pass through a 2-flop synchroniser. `fall` is asserted when the synchronised clock was 1 in the previous cycle and is 0 in the current cycle.
- **Accepting a request.** `tx_stb` is accepted only in IDLE. It is ignored in every other state.
- **Latched frame.** On accept, the block latches a 10-bit frame `{1'b1 (stop), ~^tx_data (odd parity), tx_data}`, shifted out LSB first.
- **IDLE.** Both `oe` outputs are 0 and `tx_busy` is 0. Accepting `tx_stb` moves to INHIBIT.
- **INHIBIT.**
  - `ps2_clk_oe` = 1.
  - The counter counts `INHIBIT_CYC` cycles, then the state moves to RTS.
- **RTS.**
  - `ps2_dat_oe` = 1 (start bit) and `ps2_clk_oe` = 0.
  - The timeout counter is cleared.
  - The next cycle moves to DATA with bit index 0.
- **DATA.** On each `fall`:
  - `ps2_dat_oe` ← ~frame[idx] and idx increments.
  - Falls 1–8 present data bits 0–7, fall 9 presents parity, and fall 10 presents the stop bit (line released).
  - After fall 10 the state moves to ACK.
- **ACK.**
  - On the next `fall`, the block samples the synchronised data.
  - 0 moves to WAIT_IDLE.
  - 1 releases both lines, pulses `tx_err` and returns to IDLE.
- **WAIT_IDLE.** When the synchronised clock and data are both 1, the block pulses `tx_done` and returns to IDLE.
- **Timeout.**
  - The timeout counter runs in RTS, DATA, ACK and WAIT_IDLE.
  - When it reaches `TIMEOUT_CYC`, both lines are released, `tx_err` pulses and the state returns to IDLE. This rule overrides any edge event in the same cycle.
- **Widths.** The timeout counter is `$clog2(TIMEOUT_CYC+1)` bits and the inhibit counter is `$clog2(INHIBIT_CYC+1)` bits.

## Timing
- **Reset.**
  - While `reset_n`=0, the block asynchronously enters IDLE.
  - `ps2_clk_oe`, `ps2_dat_oe`, `tx_busy`, `tx_done` and `tx_err` are all 0, and the counters and idx are 0.
  - Reset during a transfer releases both lines immediately, with no clock edge required, and produces no `tx_err`.
- **Start latency.** `tx_busy` and `ps2_clk_oe` rise in the cycle after `tx_stb` is accepted.
- **Inhibit length.** `ps2_clk_oe` stays high for exactly `INHIBIT_CYC` cycles. `ps2_dat_oe` rises in the same cycle that `ps2_clk_oe` falls.
- **Data update latency.** `ps2_dat_oe` changes 3 cycles after the falling edge at the pin: 2 synchroniser cycles plus 1 register. At 4 MHz this is 750 ns, well inside the device's ≥30 µs clock-low phase.
- **Completion.** `tx_done` and `tx_err` are one cycle each and mutually exclusive. `tx_busy` falls in the same cycle as the pulse.
- **Back-to-back.** A new `tx_stb` can be accepted in the cycle after `tx_busy` falls.

## Test plan
- **Normal send.** `tx_stb` with `tx_data`=0xF4; the device model clocks at 12.5 kHz and drives ACK low on fall 11.
  - The device samples 0,0,1,0,1,1,1,1, then parity 0, then stop 1.
  - `tx_done` pulses once and `tx_err` stays 0.
- **Inhibit length and start bit.** Measure `ps2_clk_oe`: high for exactly 400 cycles. `ps2_dat_oe` must be 1 in the first cycle after `ps2_clk_oe` drops.
- **Parity.** `tx_data`=0x00 → parity bit 1. `tx_data`=0xFF → parity bit 1.
- **Missing ACK.** The device releases data at fall 11 → `tx_err` pulses, both oe outputs are 0, and the state is IDLE.
- **Device never clocks.** After RTS, no edges occur → `tx_err` pulses exactly 60000 cycles after RTS entry, with both lines released.
- **Busy and reset.**
  - `tx_stb` with 0xAA during a 0xF4 transfer → ignored; the device model receives 0xF4 only.
  - `reset_n` low during DATA at fall 5 → both oe outputs are 0 within the same simulation delta, with no clock edge, and no `tx_done` or `tx_err` pulses.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter using the request-to-send procedure.
// Only open-collector enables are produced; the pads live in the top-level wrapper.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 400,
    parameter int TIMEOUT_CYC = 60000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_stb,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic          clk_prev_q, clk_prev_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    idx_q, idx_d;
    logic [9:0]    frame_q, frame_d;
    logic          dat_oe_q, dat_oe_d, done_q, done_d, err_q, err_d;
    logic          fall;

    assign fall       = clk_prev_q & ~clk_sync_q[1];
    assign tx_busy    = state_q != IDLE;
    assign ps2_clk_oe = state_q == INHIBIT;
    assign ps2_dat_oe = dat_oe_q;
    assign tx_done    = done_q;
    assign tx_err     = err_q;

    always_comb begin
        state_d    = state_q;
        clk_sync_d = {clk_sync_q[0], ps2_clk_i};
        dat_sync_d = {dat_sync_q[0], ps2_dat_i};
        clk_prev_d = clk_sync_q[1];
        inh_d      = inh_q;
        tmo_d      = '0;
        idx_d      = idx_q;
        frame_d    = frame_q;
        dat_oe_d   = dat_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: if (tx_stb) begin
                state_d = INHIBIT;
                frame_d = {1'b1, ~^tx_data, tx_data};
                inh_d   = '0;
            end
            INHIBIT: if (inh_q == INH_LAST) begin
                state_d  = RTS;
                inh_d    = '0;
                dat_oe_d = 1'b1;
            end else begin
                inh_d = inh_q + IW'(1);
            end
            RTS: begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA: if (fall) begin
                dat_oe_d = ~frame_q[idx_q];
                idx_d    = idx_q + 4'd1;
                state_d  = idx_q == 4'd9 ? ACK : DATA;
            end
            ACK: if (fall) begin
                state_d = dat_sync_q[1] ? IDLE : WAIT_IDLE;
                err_d   = dat_sync_q[1];
            end
            WAIT_IDLE: if (clk_sync_q[1] && dat_sync_q[1]) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // The timeout wins over any edge handled above in the same cycle.
        if (state_q inside {RTS, DATA, ACK, WAIT_IDLE}) begin
            tmo_d = tmo_q + TW'(1);
            if (tmo_q == TMO_LAST) begin
                state_d = IDLE;
                done_d  = 1'b0;
                err_d   = 1'b1;
            end
        end
        if (state_d == IDLE) begin
            dat_oe_d = 1'b0;
            idx_d    = '0;
        end
    end

    // Synchronisers reset to the idle-high bus level so no false edge follows reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            inh_q      <= '0;
            tmo_q      <= '0;
            idx_q      <= '0;
            frame_q    <= '0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            inh_q      <= inh_d;
            tmo_q      <= tmo_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// tb_ps2_host_tx: scoreboard bench; an open-collector device model clocks frames out of ps2_host_tx.
module tb_ps2_host_tx;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_stb = 1'b0;
    logic       tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_i, ps2_dat_i;
    int         tests = 0;
    int         fails = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [9:0] exp_q[$];

    assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

    ps2_host_tx dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_stb(tx_stb),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
        .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done || tx_err) begin
            tests++;
            if ((tx_done && tx_err) || tx_busy) begin
                fails++;
                $display("FAIL pulse_excl: done=%b err=%b busy=%b, required one pulse with busy=0", tx_done, tx_err, tx_busy);
            end
        end
    end

    function automatic logic [9:0] frame_of(input logic [7:0] d);
        return {1'b1, ($countones(d) % 2) == 0, d};
    endfunction

    task automatic start(input logic [7:0] d, input bit track);
        tx_data = d;
        tx_stb  = 1'b1;
        if (track) exp_q.push_back(frame_of(d));
        @(negedge clk);
        tx_stb = 1'b0;
    endtask

    task automatic dev_receive(input int half, input bit ack, output logic [9:0] got);
        logic [9:0] exp;
        bit ok = 1'b0;
        got = 'x;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (tx_busy && !ps2_clk_oe && !ps2_dat_i) ok = 1'b1;
            else @(negedge clk);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rts_seen: no request-to-send within 2000 cycles");
            return;
        end
        for (int b = 0; b < 10; b++) begin
            repeat (half) @(negedge clk);
            dev_clk = 1'b0;
            repeat (half) @(negedge clk);
            dev_clk = 1'b1;
            got[b] = ps2_dat_i;
        end
        repeat (half / 2) @(negedge clk);
        if (ack) dev_dat = 1'b0;
        repeat (half / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (half) @(negedge clk);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL frame: got %b, required %b", got, exp);
        end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (tx_busy && n < max) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (tx_busy) begin
            fails++;
            $display("FAIL idle_wait: busy still 1 after %0d cycles, required 0", max);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe} !== 5'b0) begin
            fails++;
            $display("FAIL reset_out: got %b, required 00000", {tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({tx_busy, ps2_clk_oe, ps2_dat_oe} !== 3'b0) begin
            fails++;
            $display("FAIL idle_out: got %b, required 000", {tx_busy, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_normal_send();
        logic [9:0] got;
        int d0 = done_cnt, e0 = err_cnt;
        start(8'hF4, 1'b1);
        tests++;
        if ({tx_busy, ps2_clk_oe} !== 2'b11) begin
            fails++;
            $display("FAIL start_latency: busy,clk_oe=%b, required 11", {tx_busy, ps2_clk_oe});
        end
        dev_receive(160, 1'b1, got);
        tests++;
        if (got !== 10'b1_0_1111_0100) begin
            fails++;
            $display("FAIL bits_f4: got %b, required 1011110100", got);
        end
        wait_idle(2000);
        @(negedge clk);
        tests++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            fails++;
            $display("FAIL normal_pulses: done=%0d err=%0d, required done=1 err=0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_inhibit_parity00();
        logic [9:0] got;
        int n = 0;
        start(8'h00, 1'b1);
        while (ps2_clk_oe && n < 1000) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if (n != 400) begin
            fails++;
            $display("FAIL inhibit_len: got %0d cycles, required 400", n);
        end
        tests++;
        if (ps2_dat_oe !== 1'b1) begin
            fails++;
            $display("FAIL start_bit: dat_oe=%b, required 1", ps2_dat_oe);
        end
        dev_receive(40, 1'b1, got);
        tests++;
        if (got[8] !== 1'b1) begin
            fails++;
            $display("FAIL parity_00: got %b, required 1", got[8]);
        end
        wait_idle(500);
        @(negedge clk);
    endtask

    task automatic test_parity_ff();
        logic [9:0] got;
        start(8'hFF, 1'b1);
        dev_receive(40, 1'b1, got);
        tests++;
        if (got[8] !== 1'b1) begin
            fails++;
            $display("FAIL parity_ff: got %b, required 1", got[8]);
        end
        wait_idle(500);
        @(negedge clk);
    endtask

    task automatic test_missing_ack();
        logic [9:0] got;
        int d0 = done_cnt, e0 = err_cnt;
        start(8'h5A, 1'b1);
        dev_receive(40, 1'b0, got);
        wait_idle(500);
        @(negedge clk);
        tests++;
        if (err_cnt - e0 != 1 || done_cnt != d0) begin
            fails++;
            $display("FAIL noack_pulses: done=%0d err=%0d, required done=0 err=1", done_cnt - d0, err_cnt - e0);
        end
        tests++;
        if ({tx_busy, ps2_clk_oe, ps2_dat_oe} !== 3'b0) begin
            fails++;
            $display("FAIL noack_lines: busy,clk_oe,dat_oe=%b, required 000", {tx_busy, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_no_clock();
        int n = 0;
        start(8'h55, 1'b0);
        while (ps2_clk_oe && n < 1000) begin
            n++;
            @(negedge clk);
        end
        n = 0;
        while (!tx_err && n < 70000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n != 60000) begin
            fails++;
            $display("FAIL timeout_len: got %0d cycles, required 60000", n);
        end
        tests++;
        if ({tx_busy, ps2_clk_oe, ps2_dat_oe} !== 3'b0) begin
            fails++;
            $display("FAIL timeout_lines: busy,clk_oe,dat_oe=%b, required 000", {tx_busy, ps2_clk_oe, ps2_dat_oe});
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignored();
        logic [9:0] got;
        int d0 = done_cnt;
        start(8'hF4, 1'b1);
        repeat (50) @(negedge clk);
        tx_data = 8'hAA;
        tx_stb  = 1'b1;
        @(negedge clk);
        tx_stb = 1'b0;
        dev_receive(40, 1'b1, got);
        tests++;
        if (got[7:0] !== 8'hF4) begin
            fails++;
            $display("FAIL busy_data: got %h, required f4", got[7:0]);
        end
        wait_idle(500);
        repeat (600) @(negedge clk);
        tests++;
        if (tx_busy !== 1'b0 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL busy_ignored: busy=%b done=%0d, required busy=0 done=1", tx_busy, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt, e0 = err_cnt;
        int n = 0;
        start(8'hE5, 1'b1);
        while (!(tx_busy && !ps2_clk_oe && !ps2_dat_i) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        for (int b = 0; b < 4; b++) begin
            repeat (40) @(negedge clk);
            dev_clk = 1'b0;
            repeat (40) @(negedge clk);
            dev_clk = 1'b1;
        end
        repeat (40) @(negedge clk);
        dev_clk = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if ({tx_busy, ps2_clk_oe, ps2_dat_oe} !== 3'b101) begin
            fails++;
            $display("FAIL pre_reset: busy,clk_oe,dat_oe=%b, required 101", {tx_busy, ps2_clk_oe, ps2_dat_oe});
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({tx_busy, ps2_clk_oe, ps2_dat_oe} !== 3'b000) begin
            fails++;
            $display("FAIL async_reset: busy,clk_oe,dat_oe=%b, required 000", {tx_busy, ps2_clk_oe, ps2_dat_oe});
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        tests++;
        if (done_cnt != d0 || err_cnt != e0) begin
            fails++;
            $display("FAIL reset_pulses: done=%0d err=%0d, required 0 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] got;
        int d0 = done_cnt;
        start(8'h12, 1'b1);
        dev_receive(40, 1'b1, got);
        wait_idle(500);
        start(8'h34, 1'b1);
        tests++;
        if (tx_busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b, required 1", tx_busy);
        end
        dev_receive(40, 1'b1, got);
        wait_idle(500);
        @(negedge clk);
        tests++;
        if (done_cnt - d0 != 2) begin
            fails++;
            $display("FAIL b2b_done: got %0d, required 2", done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_normal_send();
        test_inhibit_parity00();
        test_parity_ff();
        test_missing_ack();
        test_no_clock();
        test_busy_ignored();
        test_reset_mid();
        test_back_to_back();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_left: %0d frames pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
